// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the retire trace path: record type codes, record
// field positions and the capture FSM states.
package cpu_trace_pkg;

    localparam int REC_W     = 72;

    localparam int TYPE_LSB  = 70;
    localparam int LOAD_BIT  = 69;
    localparam int RSVD_BIT  = 68;
    localparam int REG_LSB   = 64;
    localparam int INUM_LSB  = 48;
    localparam int PC_LSB    = 32;
    localparam int ADDR_LSB  = 16;
    localparam int VALUE_LSB = 0;

    typedef enum logic [1:0] {
        REC_NOP   = 2'd0,
        REC_REG   = 2'd1,
        REC_STORE = 2'd2,
        REC_HALT  = 2'd3
    } recType_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        DONE   = 2'd3
    } traceState_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is presented on popData
// whenever the FIFO is not empty, and popData reads as zero when it is empty.
module trace_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   countReg;
    logic             doPush;
    logic             doPop;

    assign full    = (countReg == (PTR_W+1)'(DEPTH));
    assign empty   = (countReg == '0);
    assign count   = countReg;
    assign doPop   = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign doPush  = push && (!full || doPop);
    assign popData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/retire_trace_fifo.sv
// Hardware retire trace: classifies each captured CPU cycle into a record and
// queues it for a valid/ready sink. Define RETIRE_TRACE_SKIP_NOP_EN to suppress NOP records.
module retire_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int INUM_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              pc,
    input  logic                     reg_write,
    input  logic [3:0]               write_reg,
    input  logic [15:0]              write_data,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [15:0]              mem_addr,
    input  logic [15:0]              mem_data,
    input  logic                     hlt,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [71:0]              rec_data,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     halted,
    output logic                     done
);

    import cpu_trace_pkg::*;

    traceState_t       state;
    traceState_t       stateNext;
    logic [INUM_W-1:0] inum;
    logic              overflowReg;
    logic [15:0]       dropCnt;

    recType_t          recType;
    logic              recLoad;
    logic [3:0]        recReg;
    logic [15:0]       recAddr;
    logic [15:0]       recValue;
    logic [REC_W-1:0]  recWord;

    logic              capture;
    logic              genRecord;
    logic              popRec;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              dropRec;

    // Register writes win over halt, halt over store; everything else is a NOP.
    always_comb begin
        recType  = REC_NOP;
        recLoad  = 1'b0;
        recReg   = '0;
        recAddr  = '0;
        recValue = '0;
        if (reg_write) begin
            recType  = REC_REG;
            recLoad  = mem_read;
            recReg   = write_reg;
            recValue = write_data;
            recAddr  = mem_read ? mem_addr : '0;
        end else if (hlt) begin
            recType = REC_HALT;
        end else if (mem_write) begin
            recType  = REC_STORE;
            recAddr  = mem_addr;
            recValue = mem_data;
        end
    end

    always_comb begin
        recWord                      = '0;
        recWord[TYPE_LSB +: 2]       = recType;
        recWord[LOAD_BIT]            = recLoad;
        recWord[RSVD_BIT]            = 1'b0;
        recWord[REG_LSB +: 4]        = recReg;
        recWord[INUM_LSB +: 16]      = 16'(inum);
        recWord[PC_LSB +: 16]        = pc;
        recWord[ADDR_LSB +: 16]      = recAddr;
        recWord[VALUE_LSB +: 16]     = recValue;
    end

    assign capture = en && ((state == IDLE) || (state == RUN));

`ifdef RETIRE_TRACE_SKIP_NOP_EN
    assign genRecord = capture && (recType != REC_NOP);
`else
    assign genRecord = capture;
`endif

    assign rec_valid = !fifoEmpty;
    assign popRec    = rec_valid && rec_ready;
    assign dropRec   = genRecord && fifoFull && !popRec;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (genRecord),
        .pushData (recWord),
        .pop      (popRec),
        .popData  (rec_data),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The halt transition happens on the capture edge even if the record is dropped.
    always_comb begin
        stateNext = state;
        halted    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    stateNext = (recType == REC_HALT) ? HALTED : RUN;
                end
            end
            RUN: begin
                if (en && (recType == REC_HALT)) begin
                    stateNext = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (occupancy == '0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                halted = 1'b1;
                done   = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inum        <= '0;
            overflowReg <= 1'b0;
            dropCnt     <= '0;
        end else begin
            if (genRecord) begin
                inum <= inum + 1'b1;
            end
            if (dropRec) begin
                overflowReg <= 1'b1;
                if (dropCnt != 16'hFFFF) begin
                    dropCnt <= dropCnt + 16'd1;
                end
            end
        end
    end

    assign overflow = overflowReg;
    assign drop_cnt = dropCnt;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo: table-driven capture vectors and
// hand-written full/halt/reset sequences, scored against a queue of expected records.
module tb_retire_trace_fifo;

    import cpu_trace_pkg::*;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic        en;
        logic        ready;
        logic [15:0] pc;
        logic        regWrite;
        logic [3:0]  writeReg;
        logic [15:0] writeData;
        logic        memRead;
        logic        memWrite;
        logic [15:0] memAddr;
        logic [15:0] memData;
        logic        hlt;
        logic [1:0]  expType;
        logic        expLoad;
        logic [3:0]  expReg;
        logic [15:0] expAddr;
        logic [15:0] expValue;
    } stim_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] pc;
    logic        reg_write;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        hlt;
    logic        rec_valid;
    logic        rec_ready;
    logic [71:0] rec_data;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [4:0]  occupancy;
    logic        halted;
    logic        done;

    logic [71:0] sbQ [$];
    int          modelInum;
    bit          modelHalted;
    bit          modelDone;
    bit          modelOverflow;
    int          modelDrops;
    int          checkCount;
    int          passCount;
    int          dutXfers;
    logic [1:0]  lastXferType;
    stim_t       vectors [8];

    retire_trace_fifo #(
        .DEPTH  (DEPTH),
        .INUM_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pc         (pc),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .hlt        (hlt),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .occupancy  (occupancy),
        .halted     (halted),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkStatus();
        checkOutput("recValid",  72'(rec_valid), 72'(sbQ.size() > 0));
        checkOutput("occupancy", 72'(occupancy), 72'(sbQ.size()));
        checkOutput("overflow",  72'(overflow),  72'(modelOverflow));
        checkOutput("dropCnt",   72'(drop_cnt),  72'(modelDrops));
        checkOutput("halted",    72'(halted),    72'(modelHalted));
        checkOutput("done",      72'(done),      72'(modelDone));
    endtask

    function automatic stim_t idleStim(input logic ready);
        stim_t s;
        s       = '0;
        s.ready = ready;
        return s;
    endfunction

    function automatic stim_t mkReg(input logic [15:0] p, input logic [3:0] r, input logic [15:0] d, input logic ready);
        stim_t s;
        s           = '0;
        s.en        = 1'b1;
        s.ready     = ready;
        s.pc        = p;
        s.regWrite  = 1'b1;
        s.writeReg  = r;
        s.writeData = d;
        s.expType   = 2'd1;
        s.expReg    = r;
        s.expValue  = d;
        return s;
    endfunction

    function automatic stim_t mkNop(input logic [15:0] p, input logic ready);
        stim_t s;
        s       = '0;
        s.en    = 1'b1;
        s.ready = ready;
        s.pc    = p;
        return s;
    endfunction

    // Drives one cycle, retires the expected head on a transfer and predicts the new record.
    task automatic applyStimulus(input stim_t s);
        logic [71:0] expRec;
        bit          gen;
        bit          doneNext;
        en         = s.en;
        rec_ready  = s.ready;
        pc         = s.pc;
        reg_write  = s.regWrite;
        write_reg  = s.writeReg;
        write_data = s.writeData;
        mem_read   = s.memRead;
        mem_write  = s.memWrite;
        mem_addr   = s.memAddr;
        mem_data   = s.memData;
        hlt        = s.hlt;
        if (rec_valid && s.ready) begin
            dutXfers++;
            lastXferType = rec_data[71:70];
        end
        doneNext = modelDone || (modelHalted && (sbQ.size() == 0));
        if ((sbQ.size() > 0) && s.ready) begin
            expRec = sbQ.pop_front();
            checkOutput("recData", rec_data, expRec);
        end
        gen = s.en && !modelHalted;
`ifdef RETIRE_TRACE_SKIP_NOP_EN
        if (s.expType == 2'd0) gen = 1'b0;
`endif
        if (gen) begin
            expRec = {s.expType, s.expLoad, 1'b0, s.expReg, 16'(modelInum), s.pc, s.expAddr, s.expValue};
            modelInum = (modelInum + 1) % 65536;
            if (sbQ.size() == DEPTH) begin
                modelOverflow = 1'b1;
                if (modelDrops < 65535) modelDrops++;
            end else begin
                sbQ.push_back(expRec);
            end
            if (s.expType == 2'd3) modelHalted = 1'b1;
        end
        modelDone = doneNext;
        @(negedge clk);
        checkStatus();
    endtask

    task automatic clearModel();
        sbQ.delete();
        modelInum     = 0;
        modelHalted   = 1'b0;
        modelDone     = 1'b0;
        modelOverflow = 1'b0;
        modelDrops    = 0;
    endtask

    task automatic resetDut();
        applyInputsIdle();
        rst = 1'b1;
        #1;
        clearModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyInputsIdle();
        en = 1'b0; rec_ready = 1'b0; pc = '0; reg_write = 1'b0; write_reg = '0;
        write_data = '0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
        mem_data = '0; hlt = 1'b0;
    endtask

    task automatic drainQueue();
        int guard;
        guard = 0;
        while ((sbQ.size() > 0) && (guard < 64)) begin
            applyStimulus(idleStim(1'b1));
            guard++;
        end
        checkOutput("drainEmpty", 72'(occupancy), 72'(0));
    endtask

    initial begin
        stim_t s;
        int    guard;
        checkCount   = 0;
        passCount    = 0;
        dutXfers     = 0;
        lastXferType = '0;
        clearModel();
        applyInputsIdle();
        rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rstRecValid",  72'(rec_valid), 72'(0));
        checkOutput("rstRecData",   rec_data,       72'(0));
        checkOutput("rstOccupancy", 72'(occupancy), 72'(0));
        checkOutput("rstOverflow",  72'(overflow),  72'(0));
        checkOutput("rstDropCnt",   72'(drop_cnt),  72'(0));
        checkOutput("rstHalted",    72'(halted),    72'(0));
        checkOutput("rstDone",      72'(done),      72'(0));
        rst = 1'b0;

        // Classification vectors with hand-derived expected fields
        vectors[0] = mkReg(16'h0004, 4'd3, 16'h00AB, 1'b1);
        s = mkReg(16'h0006, 4'd5, 16'h5555, 1'b1);
        s.memRead = 1'b1; s.memAddr = 16'h0100; s.expLoad = 1'b1; s.expAddr = 16'h0100;
        vectors[1] = s;
        s = idleStim(1'b1);
        s.en = 1'b1; s.pc = 16'h0008; s.writeReg = 4'd2; s.writeData = 16'h9999;
        s.memWrite = 1'b1; s.memAddr = 16'h0200; s.memData = 16'h1234;
        s.expType = 2'd2; s.expAddr = 16'h0200; s.expValue = 16'h1234;
        vectors[2] = s;
        s = mkNop(16'h000A, 1'b0);
        s.memAddr = 16'h7777; s.memData = 16'h8888; s.writeData = 16'h6666; s.writeReg = 4'd9;
        vectors[3] = s;
        s = mkReg(16'h00F0, 4'd4, 16'h1111, 1'b0);
        s.en = 1'b0;
        vectors[4] = s;
        s = mkReg(16'h000C, 4'd7, 16'hBEEF, 1'b0);
        s.memWrite = 1'b1; s.memAddr = 16'h0300; s.memData = 16'h4444;
        vectors[5] = s;
        s = idleStim(1'b1);
        s.en = 1'b1; s.pc = 16'h000E; s.memRead = 1'b1; s.memWrite = 1'b1;
        s.memAddr = 16'h0400; s.memData = 16'h00FF;
        s.expType = 2'd2; s.expAddr = 16'h0400; s.expValue = 16'h00FF;
        vectors[6] = s;
        s = mkNop(16'h0010, 1'b1);
        s.memRead = 1'b1; s.memAddr = 16'h0500;
        vectors[7] = s;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i]);
        end
        drainQueue();

        // Full FIFO: fill, push+pop at full, then overflow
        resetDut();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mkReg(16'h1000 + 16'(i), 4'd1, 16'(i), 1'b0));
        end
        checkOutput("fullOcc", 72'(occupancy), 72'(16));
        checkOutput("fullOvf", 72'(overflow),  72'(0));
        applyStimulus(mkReg(16'h1100, 4'd2, 16'hC0DE, 1'b1));
        checkOutput("pushPopOcc",  72'(occupancy), 72'(16));
        checkOutput("pushPopOvf",  72'(overflow),  72'(0));
        checkOutput("pushPopDrop", 72'(drop_cnt),  72'(0));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mkReg(16'h1200 + 16'(i), 4'd3, 16'hDD00 + 16'(i), 1'b0));
        end
        checkOutput("dropOcc",  72'(occupancy), 72'(16));
        checkOutput("dropOvf",  72'(overflow),  72'(1));
        checkOutput("dropCnt2", 72'(drop_cnt),  72'(2));
        drainQueue();

        // Asynchronous reset with records in flight
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mkReg(16'h2000 + 16'(i), 4'd6, 16'h2200 + 16'(i), 1'b0));
        end
        checkOutput("preRstOcc", 72'(occupancy), 72'(5));
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRecValid", 72'(rec_valid), 72'(0));
        checkOutput("asyncRecData",  rec_data,       72'(0));
        checkOutput("asyncOcc",      72'(occupancy), 72'(0));
        checkOutput("asyncOvf",      72'(overflow),  72'(0));
        checkOutput("asyncDrop",     72'(drop_cnt),  72'(0));
        clearModel();
        applyInputsIdle();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mkReg(16'h2100, 4'd8, 16'h0808, 1'b1));
        drainQueue();

        // Halt with three records queued, then drain to done
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkReg(16'h0010 + 16'(2 * i), 4'd2, 16'h3300 + 16'(i), 1'b0));
        end
        dutXfers = 0;
        s = mkNop(16'h0020, 1'b1);
        s.hlt = 1'b1; s.memWrite = 1'b1; s.memAddr = 16'h0999; s.expType = 2'd3;
        applyStimulus(s);
        checkOutput("haltedNext", 72'(halted), 72'(1));
        guard = 0;
        while (!modelDone && (guard < 32)) begin
            applyStimulus(mkReg(16'h0022, 4'd1, 16'hAAAA, 1'b1));
            guard++;
        end
        checkOutput("haltDone",   72'(done),         72'(1));
        checkOutput("haltXfers",  72'(dutXfers),     72'(4));
        checkOutput("haltLastTy", 72'(lastXferType), 72'(3));

        // NOP runs followed by a register write
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkNop(16'h0030 + 16'(i), 1'b1));
        end
        applyStimulus(mkReg(16'h0040, 4'd2, 16'h0042, 1'b1));
        drainQueue();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
